// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: 1 + WAIT_STATES data-phase cycles per OKAY transfer, 2 per ERROR.
// Backpressure via hreadyout low during wait/first error cycle; write data committed on final edge.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hB000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t        state, next_state;
  logic [2:0]    cnt, next_cnt;
  logic          p_vld, p_write;
  logic [AW-1:0] p_idx;
  logic [1:0]    p_off, p_size;
  logic [31:0]   mem [MEM_DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] a_idx;
  logic          a_err, take, final_cyc, commit;
  logic [3:0]    be;
  logic [31:0]   fwd_word;
  logic          unused_htrans;

  assign offset        = haddr - BASE_ADDR;
  assign a_idx         = offset[AW+1:2];
  assign unused_htrans = htrans[0];
  assign a_err = (hsize > 3'b010)
               | ((hsize == 3'b001) & offset[0])
               | ((hsize == 3'b010) & (offset[1:0] != 2'b00))
               | (offset >= 32'(MEM_DEPTH * 4));

  assign hreadyout = (state != S_WAIT) && (state != S_ERR1);
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign take      = hsel & hready & htrans[1] & hreadyout;
  assign final_cyc = (state == S_IDLE) & p_vld;
  assign commit    = final_cyc & p_write & ~reset;

  always_comb begin
    be = 4'b0000;
    case (p_size)
      2'd0:    be = 4'b0001 << p_off;
      2'd1:    be = p_off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Zero-wait read hitting the word being written this cycle sees the new lanes.
  always_comb begin
    fwd_word = mem[a_idx];
    for (int b = 0; b < 4; b++) begin
      if (commit && (p_idx == a_idx) && be[b])
        fwd_word[b*8 +: 8] = hwdata[b*8 +: 8];
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      S_IDLE, S_ERR2: begin
        next_state = S_IDLE;
        if (take) begin
          if (a_err) begin
            next_state = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            next_state = S_WAIT;
            next_cnt   = 3'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 3'd0) next_state = S_IDLE;
        else             next_cnt   = cnt - 3'd1;
      end
      S_ERR1:  next_state = S_ERR2;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      p_vld   <= 1'b0;
      p_write <= 1'b0;
      p_idx   <= '0;
      p_off   <= 2'd0;
      p_size  <= 2'd0;
      hrdata  <= 32'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (take) begin
        p_vld   <= ~a_err;
        p_write <= hwrite;
        p_idx   <= a_idx;
        p_off   <= offset[1:0];
        p_size  <= hsize[1:0];
      end else if (final_cyc) begin
        p_vld <= 1'b0;
      end
      if (take && !a_err && !hwrite && (WAIT_STATES == 0))
        hrdata <= fwd_word;
      else if ((state == S_WAIT) && (cnt == 3'd0) && !p_write)
        hrdata <= mem[p_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[p_idx][b*8 +: 8] <= hwdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (1 and 0 wait states) driven with directed and random
// pipelined AHB transfers, checked against a byte-level memory model with known-byte tracking.
module tb_ahb_sram_slave;
  localparam logic [31:0] BASE = 32'hB000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset, hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0] haddr [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize [2];

  assign hready = hreadyout;

  ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(256), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .reset(reset[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(hready[0]),
    .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]));

  ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(reset[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(hready[1]),
    .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: memory bytes plus a flag for bytes whose content is known.
  logic [7:0]  mdl [2][256][4];
  bit          kn  [2][256][4];
  bit          p_act [2];
  bit          p_wr  [2];
  bit          p_err [2];
  int          p_idx [2];
  int          p_off [2];
  int          p_sz  [2];
  logic [31:0] p_wdata [2];
  logic [31:0] p_exp [2];
  logic [31:0] p_mask [2];
  logic [31:0] last_rd [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit lane_en(input int sz, input int off, input int b);
    if (sz == 0) return b == off;
    if (sz == 1) return (b == off) || (b == off + 1);
    return sz == 2;
  endfunction

  task automatic check_cycle(input int d, input int k);
    if (!p_act[d]) begin
      chk("idle_rdy", 32'(hreadyout[d]), 32'd1);
      chk("idle_resp", 32'(hresp[d]), 32'd0);
    end else if (p_err[d]) begin
      chk("err_rdy", 32'(hreadyout[d]), 32'(k >= 1));
      chk("err_resp", 32'(hresp[d]), 32'd1);
    end else begin
      chk("ok_rdy", 32'(hreadyout[d]), 32'(k >= ws_of(d)));
      chk("ok_resp", 32'(hresp[d]), 32'd0);
      if (k >= ws_of(d) && !p_wr[d]) begin
        last_rd[d] = hrdata[d];
        if (p_mask[d] != 32'd0)
          chk("rdata", hrdata[d] & p_mask[d], p_exp[d] & p_mask[d]);
      end
    end
  endtask

  // Presents one address phase, overlapping the previous transfer's data phase.
  task automatic issue(input int d, input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    int k = 0;
    bit done = 0;
    logic [31:0] off;
    while (!done) begin
      @(negedge clk);
      check_cycle(d, k);
      hsel[d]   = sel;
      htrans[d] = tr;
      hwrite[d] = wr;
      hsize[d]  = sz;
      haddr[d]  = addr;
      hwdata[d] = (p_act[d] && p_wr[d] && k >= ws_of(d)) ? p_wdata[d] : $urandom;
      if (hreadyout[d]) done = 1;
      else begin
        k++;
        if (k > 12) begin
          chk("stall_bound", 32'd0, 32'd1);
          done = 1;
        end
      end
    end
    @(posedge clk);
    if (p_act[d] && p_wr[d] && !p_err[d]) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en(p_sz[d], p_off[d], b)) begin
          mdl[d][p_idx[d]][b] = p_wdata[d][b*8 +: 8];
          kn[d][p_idx[d]][b]  = 1'b1;
        end
      end
    end
    p_act[d] = sel && tr[1];
    if (p_act[d]) begin
      off        = addr - BASE;
      p_wr[d]    = wr;
      p_sz[d]    = int'(sz);
      p_off[d]   = int'(off % 4);
      p_idx[d]   = int'((off / 4) % 256);
      p_wdata[d] = wd;
      p_err[d]   = (sz > 3'd2) || (sz == 3'd1 && off[0]) ||
                   (sz == 3'd2 && off % 4 != 0) || (off >= 32'd1024);
      p_exp[d]   = 32'd0;
      p_mask[d]  = 32'd0;
      if (!p_err[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (kn[d][p_idx[d]][b]) begin
            p_exp[d][b*8 +: 8]  = mdl[d][p_idx[d]][b];
            p_mask[d][b*8 +: 8] = 8'hFF;
          end
        end
      end
    end
  endtask

  task automatic flush(input int d);
    issue(d, 1'b0, 2'b00, 1'b0, 3'd2, BASE, 32'd0);
  endtask

  initial begin
    reset = 2'b11;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; hsize[d] = 3'd2;
      haddr[d] = BASE; hwdata[d] = 32'd0; p_act[d] = 1'b0; last_rd[d] = 32'd0;
      for (int i = 0; i < 256; i++)
        for (int b = 0; b < 4; b++) kn[d][i][b] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(hreadyout[d]), 32'd1);
      chk("rst_resp", 32'(hresp[d]), 32'd0);
      chk("rst_rdata", hrdata[d], 32'd0);
    end
    reset = 2'b00;

    // One wait state instance.
    issue(0, 1, 2'b10, 1, 3'd2, BASE, 32'h1234_5678);
    issue(0, 1, 2'b10, 0, 3'd2, BASE, 32'd0);
    issue(0, 1, 2'b10, 1, 3'd2, BASE + 4, 32'hFFFF_FFFF);
    chk("rd_word0", last_rd[0], 32'h1234_5678);
    issue(0, 1, 2'b10, 1, 3'd0, BASE + 5, 32'h0000_AB00);
    issue(0, 1, 2'b10, 0, 3'd2, BASE + 4, 32'd0);
    issue(0, 1, 2'b10, 1, 3'd1, BASE + 1, 32'h5555_5555);
    chk("rd_byte_merge", last_rd[0], 32'hFFFF_ABFF);
    issue(0, 1, 2'b10, 0, 3'd2, BASE, 32'd0);
    issue(0, 1, 2'b10, 0, 3'd2, BASE + 32'h400, 32'd0);
    chk("rd_after_err", last_rd[0], 32'h1234_5678);
    issue(0, 1, 2'b10, 0, 3'd3, BASE, 32'd0);
    issue(0, 1, 2'b00, 0, 3'd2, BASE, 32'd0);
    issue(0, 1, 2'b10, 1, 3'd2, BASE + 12, 32'h0BAD_F00D);
    issue(0, 1, 2'b10, 1, 3'd2, BASE + 12, 32'hDEAD_BEEF);
    @(negedge clk);
    check_cycle(0, 0);
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'hDEAD_BEEF;
    reset[0] = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(hreadyout[0]), 32'd1);
    chk("mid_rst_resp", 32'(hresp[0]), 32'd0);
    chk("mid_rst_rdata", hrdata[0], 32'd0);
    p_act[0] = 1'b0;
    @(negedge clk);
    reset[0] = 1'b0;
    issue(0, 1, 2'b10, 0, 3'd2, BASE + 12, 32'd0);
    flush(0);
    chk("rd_after_rst", last_rd[0], 32'h0BAD_F00D);

    // Zero wait state instance: write then read of the same word back to back.
    issue(1, 1, 2'b10, 1, 3'd2, BASE + 8, 32'hCAFE_F00D);
    issue(1, 1, 2'b10, 0, 3'd2, BASE + 8, 32'd0);
    flush(1);
    chk("fwd_read", last_rd[1], 32'hCAFE_F00D);
    issue(1, 1, 2'b10, 1, 3'd0, BASE + 10, 32'h0077_0000);
    issue(1, 1, 2'b10, 0, 3'd2, BASE + 8, 32'd0);
    flush(1);
    chk("fwd_byte", last_rd[1], 32'hCA77_F00D);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 300; n++) begin
        logic [31:0] off;
        logic [2:0]  sz;
        off = ($urandom % 10 == 0) ? 32'h400 + ($urandom % 16) : ($urandom % 64);
        sz  = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
        issue(d, ($urandom % 8) != 0, 2'($urandom % 4), 1'($urandom % 2), sz, BASE + off, $urandom);
      end
      flush(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
